// File: rtl/conware_pkg.sv
// Shared constants for the Game-of-Life row engine.
// B3/S23 rule thresholds and FSM state encoding.
package conware_pkg;

   localparam int NCOUNT_W = 4;

   localparam logic [NCOUNT_W-1:0] BIRTH_N    = 4'd3;
   localparam logic [NCOUNT_W-1:0] SURVIVE_LO = 4'd2;
   localparam logic [NCOUNT_W-1:0] SURVIVE_HI = 4'd3;

   localparam logic [1:0] ACCEPT    = 2'd0;
   localparam logic [1:0] EMIT      = 2'd1;
   localparam logic [1:0] EMIT_LAST = 2'd2;

endpackage

// File: rtl/conware_row_next.sv
// Combinational B3/S23 next-generation for one row.
// Columns outside the row read as dead cells.
module conware_row_next
   import conware_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] above,
   input  logic [WIDTH-1:0] middle,
   input  logic [WIDTH-1:0] below,
   output logic [WIDTH-1:0] next
);

   logic [WIDTH+1:0] a_p;
   logic [WIDTH+1:0] m_p;
   logic [WIDTH+1:0] b_p;

   assign a_p = {1'b0, above, 1'b0};
   assign m_p = {1'b0, middle, 1'b0};
   assign b_p = {1'b0, below, 1'b0};

   for (genvar c = 0; c < WIDTH; c++) begin : g_col
      logic [NCOUNT_W-1:0] n;

      assign n = NCOUNT_W'(a_p[c]) + NCOUNT_W'(a_p[c+1])
               + NCOUNT_W'(a_p[c+2]) + NCOUNT_W'(m_p[c])
               + NCOUNT_W'(m_p[c+2]) + NCOUNT_W'(b_p[c])
               + NCOUNT_W'(b_p[c+1]) + NCOUNT_W'(b_p[c+2]);

      assign next[c] = (n == BIRTH_N)
                     || (m_p[c+1] && n >= SURVIVE_LO
                         && n <= SURVIVE_HI);
   end

endmodule

// File: rtl/conware_row_engine.sv
// Streaming Game-of-Life row engine with a two-row window.
// One generation per frame; output row r is emitted once row r+1 arrives.
module conware_row_engine
   import conware_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int HEIGHT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last
);

   localparam logic [7:0] LAST_ROW = 8'(HEIGHT - 1);

   logic [1:0]       state;
   logic [7:0]       rcnt;
   logic             last_pend;
   logic [WIDTH-1:0] above;
   logic [WIDTH-1:0] middle;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_m;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] nxt;
   logic             in_xfer;
   logic             out_xfer;

   assign in_ready  = (state == ACCEPT) && !rst;
   assign out_valid = (state != ACCEPT);
   assign out_last  = (state == EMIT_LAST);
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;

   // While emitting, the pending last row has a dead row below it.
   always_comb begin
      op_a = above;
      op_m = middle;
      op_b = in_data;
      if (state != ACCEPT) begin
         op_b = '0;
      end else if (HEIGHT == 1) begin
         op_a = '0;
         op_m = in_data;
         op_b = '0;
      end
   end

   conware_row_next #(
      .WIDTH(WIDTH)
   ) u_next (
      .above (op_a),
      .middle(op_m),
      .below (op_b),
      .next  (nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACCEPT;
         rcnt      <= '0;
         last_pend <= 1'b0;
         above     <= '0;
         middle    <= '0;
         out_data  <= '0;
      end else begin
         unique case (state)
            ACCEPT: if (in_xfer) begin
               if (HEIGHT == 1) begin
                  out_data <= nxt;
                  state    <= EMIT_LAST;
               end else if (rcnt == '0) begin
                  middle <= in_data;
                  above  <= '0;
                  rcnt   <= 8'd1;
               end else begin
                  out_data  <= nxt;
                  above     <= middle;
                  middle    <= in_data;
                  rcnt      <= rcnt + 8'd1;
                  last_pend <= (rcnt == LAST_ROW);
                  state     <= EMIT;
               end
            end
            EMIT: if (out_xfer) begin
               if (last_pend) begin
                  out_data  <= nxt;
                  last_pend <= 1'b0;
                  state     <= EMIT_LAST;
               end else begin
                  state <= ACCEPT;
               end
            end
            EMIT_LAST: if (out_xfer) begin
               above  <= '0;
               middle <= '0;
               rcnt   <= '0;
               state  <= ACCEPT;
            end
            default: state <= ACCEPT;
         endcase
      end
   end

endmodule
